// File: rtl/control_pipe.sv
// Pipelined decode control: D-stage opcode -> E/M/WB control registers; optional trap via CTRL_ILLEGAL_TRAP_EN.
// Latency: E fields one edge after D advances, M two, WB three; stallD is combinational.
// Backpressure: stallD holds fetch/decode on load-use; freeze holds every register; flushIn kills E and M.
module control_pipe #(
  parameter int OPCODEWIDTH  = 4,
  parameter int REGADDRWIDTH = 4,
  parameter int ALUCTRLWIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODEWIDTH-1:0]  opcodeD,
  input  logic                    validD,
  input  logic [REGADDRWIDTH-1:0] rs1D,
  input  logic [REGADDRWIDTH-1:0] rs2D,
  input  logic [REGADDRWIDTH-1:0] rdD,
  input  logic                    freeze,
  input  logic                    flushIn,
  output logic                    stallD,
  output logic                    validE,
  output logic                    validM,
  output logic                    validWB,
  output logic [ALUCTRLWIDTH-1:0] aluControlE,
  output logic                    data2SelectorE,
  output logic                    writeDataEnableM,
  output logic                    outFlagM,
  output logic                    resultSelectorWB,
  output logic                    writeEnableWB,
  output logic [REGADDRWIDTH-1:0] rdE,
  output logic [REGADDRWIDTH-1:0] rdM,
  output logic [REGADDRWIDTH-1:0] rdWB,
  output logic                    illegalOp
);

  typedef struct packed {
    logic                    vld;
    logic                    we;
    logic                    d2;
    logic [ALUCTRLWIDTH-1:0] alu;
    logic                    mw;
    logic                    rs;
    logic                    out;
    logic [REGADDRWIDTH-1:0] rd;
  } e_t;

  typedef struct packed {
    logic                    vld;
    logic                    we;
    logic                    mw;
    logic                    rs;
    logic                    out;
    logic [REGADDRWIDTH-1:0] rd;
  } m_t;

  typedef struct packed {
    logic                    vld;
    logic                    we;
    logic                    rs;
    logic [REGADDRWIDTH-1:0] rd;
  } w_t;

  e_t e_q, e_d, dec;
  m_t m_q, m_d;
  w_t w_q, w_d;
  logic [2:0] alu3;
  logic       hazard;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_q, ill_d, illegal;
  assign illegal = ((opcodeD >> 4) != '0) || (opcodeD[3:0] == 4'hE);
`endif

  always_comb begin
    dec  = '0;
    alu3 = 3'b000;
    case (opcodeD)
      OPCODEWIDTH'(4'h1): begin dec.mw = 1'b1; alu3 = 3'b110; end
      OPCODEWIDTH'(4'h2): begin dec.we = 1'b1; dec.d2 = 1'b1; alu3 = 3'b111; end
      OPCODEWIDTH'(4'h3): begin dec.we = 1'b1; alu3 = 3'b110; end
      OPCODEWIDTH'(4'h4): begin dec.out = 1'b1; alu3 = 3'b110; end
      OPCODEWIDTH'(4'h5): begin dec.we = 1'b1; alu3 = 3'b000; end
      OPCODEWIDTH'(4'h6): begin dec.we = 1'b1; alu3 = 3'b001; end
      OPCODEWIDTH'(4'h7): begin dec.we = 1'b1; dec.rs = 1'b1; alu3 = 3'b110; end
      OPCODEWIDTH'(4'h8): begin dec.we = 1'b1; alu3 = 3'b011; end
      OPCODEWIDTH'(4'h9): begin dec.we = 1'b1; alu3 = 3'b101; end
      OPCODEWIDTH'(4'hA): alu3 = 3'b001;
      OPCODEWIDTH'(4'hB),
      OPCODEWIDTH'(4'hD),
      OPCODEWIDTH'(4'hF): begin dec.d2 = 1'b1; alu3 = 3'b111; end
      OPCODEWIDTH'(4'hC): alu3 = 3'b110;
      default: ;
    endcase
    dec.alu = ALUCTRLWIDTH'(alu3);
    dec.vld = 1'b1;
    dec.rd  = rdD;
    // A bubble carries nothing, not even its destination register.
    if (!validD) dec = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (illegal) dec = '0;
`endif
  end

  // Only LOAD sets the result selector, so it doubles as the load marker in E.
  assign hazard = validD && e_q.vld && e_q.rs && ((e_q.rd == rs1D) || (e_q.rd == rs2D));
  assign stallD = hazard && !freeze && !flushIn;

  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!freeze) begin
      w_d.vld = m_q.vld;
      w_d.we  = m_q.we;
      w_d.rs  = m_q.rs;
      w_d.rd  = m_q.rd;
      if (flushIn) begin
        e_d = '0;
        m_d = '0;
      end else begin
        m_d.vld = e_q.vld;
        m_d.we  = e_q.we;
        m_d.mw  = e_q.mw;
        m_d.rs  = e_q.rs;
        m_d.out = e_q.out;
        m_d.rd  = e_q.rd;
        e_d     = hazard ? '0 : dec;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_comb begin
    ill_d = ill_q;
    if (!freeze && !flushIn && !hazard && validD && illegal) ill_d = 1'b1;
  end
  assign illegalOp = ill_q;
`else
  assign illegalOp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ill_q <= 1'b0;
`endif
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ill_q <= ill_d;
`endif
    end
  end

  assign validE           = e_q.vld;
  assign aluControlE      = e_q.alu;
  assign data2SelectorE   = e_q.d2;
  assign rdE              = e_q.rd;
  assign validM           = m_q.vld;
  assign writeDataEnableM = m_q.mw;
  assign outFlagM         = m_q.out;
  assign rdM              = m_q.rd;
  assign validWB          = w_q.vld;
  assign resultSelectorWB = w_q.rs;
  assign writeEnableWB    = w_q.we;
  assign rdWB             = w_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: stimulus pushes expected stage words, a negedge monitor pops them.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcodeD = 4'h0;
  logic       validD = 1'b0;
  logic [3:0] rs1D = 4'h0, rs2D = 4'h0, rdD = 4'h0;
  logic       freeze = 1'b0, flushIn = 1'b0;
  logic       stallD, validE, validM, validWB;
  logic [2:0] aluControlE;
  logic       data2SelectorE, writeDataEnableM, outFlagM, resultSelectorWB, writeEnableWB;
  logic [3:0] rdE, rdM, rdWB;
  logic       illegalOp;

  control_pipe dut (
    .clk(clk), .rst_n(rst_n), .opcodeD(opcodeD), .validD(validD),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .freeze(freeze), .flushIn(flushIn),
    .stallD(stallD), .validE(validE), .validM(validM), .validWB(validWB),
    .aluControlE(aluControlE), .data2SelectorE(data2SelectorE),
    .writeDataEnableM(writeDataEnableM), .outFlagM(outFlagM),
    .resultSelectorWB(resultSelectorWB), .writeEnableWB(writeEnableWB),
    .rdE(rdE), .rdM(rdM), .rdWB(rdWB), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] qE[$];
  logic [5:0] qM[$];
  logic [5:0] qW[$];
  logic       frz_edge = 1'b0;
  logic [24:0] outs, snap;

  assign outs = {stallD, validE, validM, validWB, aluControlE, data2SelectorE,
                 writeDataEnableM, outFlagM, resultSelectorWB, writeEnableWB,
                 rdE, rdM, rdWB, illegalOp};

  // {we, d2, alu[2:0], memWrite, resultSel, out} straight from the decode table
  function automatic logic [7:0] ctl(input logic [3:0] op);
    case (op)
      4'h1: ctl = 8'b0_0_110_1_0_0;
      4'h2: ctl = 8'b1_1_111_0_0_0;
      4'h3: ctl = 8'b1_0_110_0_0_0;
      4'h4: ctl = 8'b0_0_110_0_0_1;
      4'h5: ctl = 8'b1_0_000_0_0_0;
      4'h6: ctl = 8'b1_0_001_0_0_0;
      4'h7: ctl = 8'b1_0_110_0_1_0;
      4'h8: ctl = 8'b1_0_011_0_0_0;
      4'h9: ctl = 8'b1_0_101_0_0_0;
      4'hA: ctl = 8'b0_0_001_0_0_0;
      4'hB, 4'hD, 4'hF: ctl = 8'b0_1_111_0_0_0;
      4'hC: ctl = 8'b0_0_110_0_0_0;
      default: ctl = 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_instr(input logic [3:0] op, input logic [3:0] rd, input int reach);
    logic [7:0] c;
    c = ctl(op);
    if (reach >= 1) qE.push_back({c[6], c[5:3], rd});
    if (reach >= 2) qM.push_back({c[2], c[0], rd});
    if (reach >= 3) qW.push_back({c[7], c[1], rd});
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] s1, input logic [3:0] s2);
    opcodeD = op; rdD = rd; rs1D = s1; rs2D = s2; validD = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] s1,
                      input logic [3:0] s2, input int reach);
    expect_instr(op, rd, reach);
    drive(op, rd, s1, s2);
    @(posedge clk); #1;
    validD = 1'b0;
  endtask

  task automatic idle(input int n);
    validD = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_use(input logic [3:0] ld_rd, input logic [3:0] s1, input logic [3:0] s2,
                          input logic exp_stall);
    send(4'h7, ld_rd, 4'h0, 4'h0, 3);
    expect_instr(4'h5, 4'h5, 3);
    drive(4'h5, 4'h5, s1, s2);
    @(negedge clk);
    check("stall_detect", stallD, exp_stall);
    if (exp_stall) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_one_cycle", stallD, 1'b0);
      check("stall_bubble_E", validE, 1'b0);
    end
    @(posedge clk); #1;
    validD = 1'b0;
    @(negedge clk);
    check("use_in_E", {validE, aluControlE, rdE}, {1'b1, 3'b000, 4'h5});
  endtask

  always @(posedge clk) frz_edge = freeze;

  always @(negedge clk) begin
    if (rst_n && !frz_edge) begin
      if (validE) begin
        if (qE.size() == 0) check("E_unexpected", 1, 0);
        else check("E_word", {data2SelectorE, aluControlE, rdE}, qE.pop_front());
      end else check("E_bubble", {data2SelectorE, aluControlE, rdE}, 0);
      if (validM) begin
        if (qM.size() == 0) check("M_unexpected", 1, 0);
        else check("M_word", {writeDataEnableM, outFlagM, rdM}, qM.pop_front());
      end else check("M_bubble", {writeDataEnableM, outFlagM, rdM}, 0);
      if (validWB) begin
        if (qW.size() == 0) check("WB_unexpected", 1, 0);
        else check("WB_word", {writeEnableWB, resultSelectorWB, rdWB}, qW.pop_front());
      end else check("WB_bubble", {writeEnableWB, resultSelectorWB, rdWB}, 0);
    end
  end

  initial begin
    drive(4'h5, 4'h1, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(4'h6, 4'h2, 4'h0, 4'h0);
    @(negedge clk);
    check("reset_outputs", outs, 0);
    @(posedge clk); #1;
    check("reset_held_outputs", outs, 0);
    rst_n = 1'b1;
    send(4'h5, 4'h1, 4'h0, 4'h0, 3);
    send(4'h6, 4'h2, 4'h0, 4'h0, 3);

    send(4'h1, 4'h0, 4'h0, 4'h0, 3);
    send(4'h4, 4'h0, 4'h0, 4'h0, 3);
    idle(1);

    load_use(4'h3, 4'h3, 4'h0, 1'b1);
    load_use(4'h4, 4'h0, 4'h4, 1'b1);
    load_use(4'h3, 4'h1, 4'h2, 1'b0);

    send(4'h5, 4'h1, 4'h0, 4'h0, 3);
    send(4'h9, 4'h2, 4'h0, 4'h0, 3);
    send(4'h2, 4'h4, 4'h0, 4'h0, 1);
    drive(4'h8, 4'h8, 4'h0, 4'h0);
    flushIn = 1'b1;
    @(posedge clk); #1;
    flushIn = 1'b0; validD = 1'b0;
    @(negedge clk);
    check("flush_kills_E_M", {validE, validM, validWB}, 3'b001);

    send(4'h7, 4'h6, 4'h0, 4'h0, 1);
    drive(4'h5, 4'h5, 4'h6, 4'h0);
    flushIn = 1'b1;
    @(negedge clk);
    check("flush_beats_hazard", stallD, 1'b0);
    @(posedge clk); #1;
    flushIn = 1'b0; validD = 1'b0;
    @(negedge clk);
    check("flush_hazard_E_M", {validE, validM}, 2'b00);
    idle(2);

    send(4'h3, 4'h9, 4'h0, 4'h0, 3);
    send(4'h8, 4'hA, 4'h0, 4'h0, 3);
    freeze = 1'b1;
    @(negedge clk);
    snap = outs;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) freeze = 1'b0;
      @(negedge clk);
      check("freeze_hold", outs, snap);
    end
    idle(3);

    send(4'h6, 4'hB, 4'h0, 4'h0, 3);
    send(4'h8, 4'hC, 4'h0, 4'h0, 1);
    freeze = 1'b1; flushIn = 1'b1;
    @(negedge clk);
    snap = outs;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) freeze = 1'b0;
      @(negedge clk);
      check("freeze_beats_flush", outs, snap);
    end
    @(posedge clk); #1;
    flushIn = 1'b0;
    @(negedge clk);
    check("flush_after_freeze", {validE, validM, validWB}, 3'b001);
    idle(2);

`ifdef CTRL_ILLEGAL_TRAP_EN
    send(4'hE, 4'h7, 4'h0, 4'h0, 0);
    @(negedge clk);
    check("illegal_bubble", validE, 1'b0);
    check("illegal_flag", illegalOp, 1'b1);
    idle(3);
    check("illegal_sticky", illegalOp, 1'b1);
`else
    send(4'hE, 4'h0, 4'h0, 4'h0, 3);
    @(negedge clk);
    check("illegal_as_nop", {validE, aluControlE, data2SelectorE}, {1'b1, 3'b000, 1'b0});
    check("illegal_flag_off", illegalOp, 1'b0);
    idle(3);
`endif

    send(4'h5, 4'h1, 4'h0, 4'h0, 3);
    send(4'h6, 4'h2, 4'h0, 4'h0, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs, 0);
    qE.delete(); qM.delete(); qW.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    check("post_reset_flag", illegalOp, 1'b0);

    send(4'hB, 4'hD, 4'h0, 4'h0, 3);
    send(4'hA, 4'hE, 4'h0, 4'h0, 3);
    send(4'hC, 4'hF, 4'h0, 4'h0, 3);
    idle(4);
    check("qE_drained", qE.size(), 0);
    check("qM_drained", qM.size(), 0);
    check("qW_drained", qW.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined successor to the combinational decode control unit. Decodes the D-stage opcode and registers the resulting control word through the E, M and WB pipeline registers. Adds load-use hazard detection with bubble insertion, branch flush, a global freeze, and an optional illegal-opcode trap. Sits between the instruction fetch/decode register and the datapath stage muxes, ALU, data memory and register file.

## Interface
- OPCODEWIDTH, 4, opcode width; must be ≥4. Codes above 4'hF are illegal.
- REGADDRWIDTH, 4, register address width.
- ALUCTRLWIDTH, 3, ALU control width; must be ≥3. Codes are zero-extended.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcodeD  in  OPCODEWIDTH  D-stage opcode.
- validD  in  1  D-stage holds a real instruction.
- rs1D, rs2D, rdD  in  REGADDRWIDTH  D-stage source and destination registers.
- freeze  in  1  global stall (memory wait): every register holds.
- flushIn  in  1  branch taken in E: kill the D and E instructions.
- stallD  out  1  load-use hazard: fetch/decode must hold D.
- validE, validM, validWB  out  1  stage occupancy.
- aluControlE  out  ALUCTRLWIDTH  ALU operation.
- data2SelectorE  out  1  1 selects the immediate as ALU operand 2.
- writeDataEnableM  out  1  data-memory write.
- outFlagM  out  1  output-port strobe.
- resultSelectorWB  out  1  1 selects memory data for writeback.
- writeEnableWB  out  1  register-file write.
- rdE, rdM, rdWB  out  REGADDRWIDTH  destination register per stage.
- illegalOp  out  1  sticky illegal-opcode flag (macro-dependent).

## Operation
- Decode table: opcode → writeEnable / data2Sel / alu / memWrite / resultSel / out.
  - 0: NOP, all fields 0.
  - 1: STORE, 0/0/110/1/0/0.
  - 2: 1/1/111/0/0/0.
  - 3: 1/0/110/0/0/0.
  - 4: OUT, 0/0/110/0/0/1.
  - 5: 1/0/000/0/0/0.
  - 6: 1/0/001/0/0/0.
  - 7: LOAD, 1/0/110/0/1/0.
  - 8: 1/0/011/0/0/0.
  - 9: 1/0/101/0/0/0.
  - A: 0/0/001/0/0/0.
  - B, D, F: 0/1/111/0/0/0.
  - C: 0/0/110/0/0/0.
  - E and any code >F: illegal.
- No X is ever driven. Don't-care fields are 0.
- A bubble is validX=0 with all control fields of that stage at 0.
- Any output whose stage valid is 0 reads 0.
- Hazard: stallD=1 when all of the following hold:
  - validD, validE, and the E instruction is LOAD;
  - rdE equals rs1D or rs2D (both sources are always compared).
- stallD is combinational and is forced to 0 during freeze or flushIn.
- Priority per edge: reset > freeze > flushIn > hazard > normal advance.
  - freeze: all pipeline registers and illegalOp hold.
  - flushIn: E and M load bubbles. M is killed because E is killed; WB advances from M normally.
  - hazard: E loads a bubble; M and WB advance.
  - normal: D→E→M→WB shift each cycle.
- Registers reset: all valids 0, all control outputs 0, rdE/rdM/rdWB 0, illegalOp 0.

## Timing
- Latency from opcode at D (edge n, advancing) to outputs:
  - E outputs valid after edge n.
  - M outputs after edge n+1.
  - WB outputs after edge n+2.
- Hazard costs exactly one bubble: by the next edge the LOAD has left E.
- Reset asserted mid-operation clears all stages immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- Simultaneous flushIn and hazard: flush wins; stallD=0.
- Simultaneous freeze and flushIn: freeze wins. flushIn must be held until freeze drops.

## Configuration
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode with validD, advancing into E, enters as a bubble.
  - illegalOp sets and stays 1 until reset.
- Undefined:
  - An illegal opcode decodes as NOP with validE=1.
  - illegalOp is tied to 0.

## Test plan
- Reset: drive opcodes 5 then 6 and hold rst_n=0 → all outputs 0. After release, aluControlE=000, then 001; writeEnableWB=1 three edges after the first opcode.
- Load-use: LOAD rd=3, then opcode 5 with rs1=3 → stallD=1 for one cycle, one E bubble; opcode 5 reaches E two edges after the LOAD.
- Store/out: opcode 1, then 4 → writeDataEnableM=1 at edge 2, outFlagM=1 at edge 3; writeEnableWB stays 0.
- Flush: opcode 2 in E, opcode 8 in D, flushIn=1 → next edge validE=validM=0; the older WB instruction completes.
- Freeze: freeze=1 for 3 cycles mid-stream → all outputs constant; the pipeline resumes unchanged.
- Illegal: opcode E with validD=1.
  - Macro on: validE=0 and illegalOp=1, held until reset.
  - Macro off: validE=1 with all fields 0, and illegalOp=0.
